buzzer_driver: RTL and testbench

BUZZER_DRIVER -- requirements
Module: buzzer_driver

---
 rtl/buzzer_pkg.sv | 19 +
 rtl/buzzer_tick_gen.sv | 33 +++
 rtl/buzzer_driver.sv | 120 ++++++++++++
 tb/tb_buzzer_driver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer tone generator.
package buzzer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int PERIOD_W   = 13;
  localparam int MIN_PERIOD = 2;
  localparam int US_PER_S   = 1_000_000;

  // Counter width for a divide-by-div prescaler, never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/buzzer_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled clock cycles.
// Held at zero while disabled so each tone starts on a fresh tick boundary.
module buzzer_tick_gen
  import buzzer_pkg::*;
#(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..DIV-1 while enabled, wrap on the tick, otherwise hold at zero.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/buzzer_driver.sv
// Square-wave buzzer driver: plays a tone whose period is given in
// microseconds, retuning only at period boundaries so the output never glitches.
module buzzer_driver
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                iEnable,
  input  logic [PERIOD_W-1:0] iPeriod,
  output logic                oBuzzer,
  output logic                oBusy,
  output logic                oCycleDone
);

  localparam int TICK_DIV = CLK_HZ / US_PER_S;

  state_t              state;
  state_t              state_next;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] hi;
  logic [PERIOD_W-1:0] lo;
  logic [PERIOD_W-1:0] us_cnt;
  logic                tick;
  logic                tone_valid;
  logic                phase_end;
  logic                load;
  logic                tick_clr;
  logic                tick_en;

  assign tone_valid = iEnable && (iPeriod >= PERIOD_W'(MIN_PERIOD));

  // Odd periods put the extra microsecond in the LOW phase.
  assign hi = period >> 1;
  assign lo = period - hi;

  // A new period is captured when a tone starts or when a LOW phase completes
  // and the request is still valid; mid-period iPeriod changes are ignored.
  assign load = tone_valid &&
                ((state == IDLE) || ((state == LOW) && phase_end));

  assign tick_en  = (state != IDLE);
  assign tick_clr = (state == IDLE) && tone_valid;

  buzzer_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (iClk),
    .rst  (iReset),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  // Detect the final tick of the current HIGH or LOW phase.
  always_comb begin
    phase_end = 1'b0;
    case (state)
      HIGH:    phase_end = tick && (us_cnt == hi - PERIOD_W'(1));
      LOW:     phase_end = tick && (us_cnt == lo - PERIOD_W'(1));
      default: phase_end = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a dropped enable always wins over a phase change.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (tone_valid) state_next = HIGH;
      end
      HIGH: begin
        if (!iEnable)       state_next = IDLE;
        else if (phase_end) state_next = LOW;
      end
      LOW: begin
        if (!iEnable)       state_next = IDLE;
        else if (phase_end) state_next = tone_valid ? HIGH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state; the period-complete pulse is
  // suppressed while reset is asserted.
  always_comb begin
    oBuzzer    = (state == HIGH);
    oBusy      = (state != IDLE);
    oCycleDone = (state == LOW) && phase_end && !iReset;
  end

  // Latched tone period.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      period <= '0;
    end else if (load) begin
      period <= iPeriod;
    end
  end

  // Microsecond counter within the current phase.
  always_ff @(posedge iClk) begin
    if (iReset || (state == IDLE)) begin
      us_cnt <= '0;
    end else if (tick) begin
      us_cnt <= phase_end ? '0 : us_cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: tb/tb_buzzer_driver.sv
// Testbench for buzzer_driver at CLK_HZ = 4 MHz (4 clocks per microsecond).
module tb_buzzer_driver;

  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [12:0] per;
  logic        buz;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  buzzer_driver #(
    .CLK_HZ (4_000_000)
  ) dut (
    .iClk       (clk),
    .iReset     (rst),
    .iEnable    (en),
    .iPeriod    (per),
    .oBuzzer    (buz),
    .oBusy      (busy),
    .oCycleDone (done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase kind (0 silent, 1 high, 2 low), clocks left in phase.
  int m_on;
  int m_left;
  int m_p;

  logic s_buz, s_busy, s_done;
  logic tr_buz[$];
  logic tr_busy[$];
  logic tr_done[$];

  typedef struct {
    int period;
    int exp_hi;
    int exp_lo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic [12:0] p);
    int pi;
    pi = int'(p);
    if (r) begin
      m_on = 0;
    end else if (m_on == 0) begin
      if (e && pi >= 2) begin
        m_p = pi; m_on = 1; m_left = (pi / 2) * TICK;
      end
    end else if (!e) begin
      m_on = 0;
    end else if (m_left > 1) begin
      m_left--;
    end else if (m_on == 1) begin
      m_on = 2; m_left = (m_p - m_p / 2) * TICK;
    end else if (pi >= 2) begin
      m_p = pi; m_on = 1; m_left = (pi / 2) * TICK;
    end else begin
      m_on = 0;
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic r, input logic e, input logic [12:0] p);
    #1;
    rst = r; en = e; per = p;
    @(negedge clk);
    s_buz = buz; s_busy = busy; s_done = done;
    chk("model_buzzer", 32'(s_buz),  32'(m_on == 1));
    chk("model_busy",   32'(s_busy), 32'(m_on != 0));
    chk("model_done",   32'(s_done), 32'(!r && m_on == 2 && m_left == 1));
    tr_buz.push_back(s_buz);
    tr_busy.push_back(s_busy);
    tr_done.push_back(s_done);
    @(posedge clk);
    model_update(r, e, p);
  endtask

  task automatic clear_trace();
    tr_buz.delete(); tr_busy.delete(); tr_done.delete();
  endtask

  function automatic int run_at(input int start, input logic v);
    int n = 0;
    for (int i = start; i < tr_buz.size(); i++) begin
      if (tr_buz[i] !== v) break;
      n++;
    end
    return n;
  endfunction

  function automatic int count_ones_done();
    int n = 0;
    foreach (tr_done[i]) if (tr_done[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_ones_busy();
    int n = 0;
    foreach (tr_busy[i]) if (tr_busy[i] !== 1'b0) n++;
    return n;
  endfunction

  initial begin
    int e_r;
    int p_r;
    int last;

    vecs[0] = '{10,    20,    20};
    vecs[1] = '{7,     12,    16};
    vecs[2] = '{6,     12,    12};
    vecs[3] = '{2,      4,     4};
    vecs[4] = '{3,      4,     8};
    vecs[5] = '{101,  200,   204};
    vecs[6] = '{8191, 16380, 16384};

    rst = 1'b1; en = 1'b0; per = '0;
    m_on = 0; m_left = 0; m_p = 0;
    repeat (2) @(posedge clk);

    // Reset state, even with a valid tone requested.
    step(1'b1, 1'b1, 13'd10);
    chk("reset_buzzer", 32'(s_buz), 32'd0);
    chk("reset_busy",   32'(s_busy), 32'd0);
    chk("reset_done",   32'(s_done), 32'd0);

    // Table: full period shapes from reset release.
    foreach (vecs[k]) begin
      step(1'b1, 1'b0, 13'd0);
      clear_trace();
      last = vecs[k].exp_hi + vecs[k].exp_lo + 1;
      for (int i = 0; i <= last; i++) step(1'b0, 1'b1, 13'(vecs[k].period));
      chk($sformatf("latency_p%0d", vecs[k].period), 32'(tr_buz[0]), 32'd0);
      chk($sformatf("high_len_p%0d", vecs[k].period), 32'(run_at(1, 1'b1)), 32'(vecs[k].exp_hi));
      chk($sformatf("low_len_p%0d", vecs[k].period),
          32'(run_at(1 + vecs[k].exp_hi, 1'b0)), 32'(vecs[k].exp_lo));
      chk($sformatf("done_pos_p%0d", vecs[k].period), 32'(tr_done[last - 1]), 32'd1);
      chk($sformatf("done_cnt_p%0d", vecs[k].period), 32'(count_ones_done()), 32'd1);
      chk($sformatf("no_gap_p%0d", vecs[k].period), 32'(tr_buz[last]), 32'd1);
    end

    // Retune mid-HIGH: 10 -> 6.
    step(1'b1, 1'b0, 13'd0);
    clear_trace();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 13'd10);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 13'd6);
    chk("retune_high0", 32'(run_at(1, 1'b1)),  32'd20);
    chk("retune_low0",  32'(run_at(21, 1'b0)), 32'd20);
    chk("retune_done0", 32'(tr_done[40]), 32'd1);
    chk("retune_high1", 32'(run_at(41, 1'b1)), 32'd12);
    chk("retune_low1",  32'(run_at(53, 1'b0)), 32'd12);
    chk("retune_done1", 32'(tr_done[64]), 32'd1);

    // Invalid periods never start a tone.
    step(1'b1, 1'b0, 13'd0);
    clear_trace();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 13'd1);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 13'd0);
    chk("invalid_busy", 32'(count_ones_busy()), 32'd0);
    chk("invalid_buzz", 32'(run_at(0, 1'b0)), 32'd60);

    // Enable dropped mid-LOW.
    step(1'b1, 1'b0, 13'd0);
    clear_trace();
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 13'd10);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 13'd10);
    chk("drop_low_busy_before", 32'(tr_busy[26]), 32'd1);
    chk("drop_low_busy_after",  32'(tr_busy[27]), 32'd0);
    chk("drop_low_no_done",     32'(count_ones_done()), 32'd0);

    // Enable dropped on the LOW-end cycle: period completes, then silence.
    step(1'b1, 1'b0, 13'd0);
    clear_trace();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 13'd10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 13'd10);
    chk("drop_end_done", 32'(tr_done[40]), 32'd1);
    chk("drop_end_busy", 32'(tr_busy[41]), 32'd0);
    chk("drop_end_buzz", 32'(tr_buz[41]),  32'd0);

    // Reset pulse mid-HIGH then a full HIGH phase after release.
    step(1'b1, 1'b0, 13'd0);
    clear_trace();
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 13'd10);
    step(1'b1, 1'b1, 13'd10);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 13'd10);
    chk("rst_mid_before", 32'(tr_buz[11]), 32'd1);
    chk("rst_mid_after",  32'(tr_buz[12]), 32'd0);
    chk("rst_mid_rehigh", 32'(run_at(13, 1'b1)), 32'd20);

    // Randomised stimulus checked against the model every cycle.
    step(1'b1, 1'b0, 13'd0);
    e_r = 1;
    p_r = 10;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) e_r = ($urandom_range(0, 3) != 0) ? 1 : 0;
      if ($urandom_range(0, 24) == 0) p_r = $urandom_range(0, 14);
      step(($urandom_range(0, 399) == 0), e_r[0], 13'(p_r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
